addsub_sequencer: RTL and testbench

Multi-cycle controller that performs N-nibble unsigned add/subtract by time-sharing one external 4-bit ripple adder/subtractor, one nibble per clock. It sequences carry propagation across nibbles, converts a negative subtraction result to sign + magnitude by a second pass through the same adder, and presents a registered result with a one-cycle done pulse. It sits between the switch/key input logic and the seven-segment display path on the DE10-Lite.

---
 rtl/addsub_sequencer.sv | 135 +++++++++++++
 tb/tb_addsub_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// Multi-nibble unsigned add/subtract controller driving one external 4-bit adder/subtractor.
// Negative differences are converted to sign + magnitude by a second negate pass.
module addsub_sequencer #(
    parameter int unsigned NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   neg,
    output logic                   cout,
    output logic [3:0]             au_x,
    output logic [3:0]             au_y,
    output logic                   au_s,
    output logic                   au_cin,
    input  logic [3:0]             au_r,
    input  logic                   au_cout
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_NEG, S_DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [IDX_W-1:0]          idx;
    logic                      c;
    logic                      op_lat;
    logic [NIBBLES-1:0][3:0]   a_lat;
    logic [NIBBLES-1:0][3:0]   b_lat;
    logic [NIBBLES-1:0][3:0]   res_q;
    logic                      last;

    assign last   = (idx == IDX_LAST);
    assign result = res_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the final carry of the add pass decides whether a negate pass is needed
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_ADD;
            S_ADD:  if (last)  state_nxt = (op_lat && !au_cout) ? S_NEG : S_DONE;
            S_NEG:  if (last)  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Adder operand selection and status decode
    always_comb begin
        au_x   = 4'h0;
        au_y   = 4'h0;
        au_s   = 1'b0;
        au_cin = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            S_ADD: begin
                au_x   = a_lat[idx];
                au_y   = b_lat[idx];
                au_s   = op_lat;
                au_cin = (idx == '0) ? op_lat : c;
                busy   = 1'b1;
            end
            S_NEG: begin
                au_y   = res_q[idx];
                au_s   = 1'b1;
                au_cin = (idx == '0) ? 1'b1 : c;
                busy   = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Operand latches, nibble index, carry chain and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lat  <= '0;
            b_lat  <= '0;
            op_lat <= 1'b0;
            idx    <= '0;
            c      <= 1'b0;
            res_q  <= '0;
            neg    <= 1'b0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_lat  <= a;
                        b_lat  <= b;
                        op_lat <= op;
                        idx    <= '0;
                        c      <= op;
                        res_q  <= '0;
                        neg    <= 1'b0;
                        cout   <= 1'b0;
                    end
                end
                S_ADD: begin
                    res_q[idx] <= au_r;
                    c          <= au_cout;
                    idx        <= last ? '0 : idx + IDX_W'(1);
                    if (last) begin
                        cout <= op_lat ? 1'b0 : au_cout;
                        neg  <= op_lat && !au_cout;
                    end
                end
                S_NEG: begin
                    res_q[idx] <= au_r;
                    c          <= au_cout;
                    idx        <= last ? '0 : idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer with NIBBLES=2 and NIBBLES=1 instances sharing clock/reset.
module tb_addsub_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // NIBBLES=2 instance
    logic       start2 = 1'b0, op2 = 1'b0;
    logic [7:0] a2 = '0, b2 = '0, result2;
    logic       busy2, done2, neg2, cout2, aus2, aucin2, aucout2;
    logic [3:0] aux2, auy2, aur2;
    logic [4:0] sum2;
    assign sum2    = {1'b0, aux2} + {1'b0, (aus2 ? ~auy2 : auy2)} + {4'b0, aucin2};
    assign aur2    = sum2[3:0];
    assign aucout2 = sum2[4];

    addsub_sequencer #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .neg(neg2), .cout(cout2),
        .au_x(aux2), .au_y(auy2), .au_s(aus2), .au_cin(aucin2),
        .au_r(aur2), .au_cout(aucout2)
    );

    // NIBBLES=1 instance
    logic       start1 = 1'b0, op1 = 1'b0;
    logic [3:0] a1 = '0, b1 = '0, result1;
    logic       busy1, done1, neg1, cout1, aus1, aucin1, aucout1;
    logic [3:0] aux1, auy1, aur1;
    logic [4:0] sum1;
    assign sum1    = {1'b0, aux1} + {1'b0, (aus1 ? ~auy1 : auy1)} + {4'b0, aucin1};
    assign aur1    = sum1[3:0];
    assign aucout1 = sum1[4];

    addsub_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .neg(neg1), .cout(cout1),
        .au_x(aux1), .au_y(auy1), .au_s(aus1), .au_cin(aucin1),
        .au_r(aur1), .au_cout(aucout1)
    );

    // Drive a one-cycle start pulse to dut2; returns in the first ADD cycle
    task automatic start_op2(input logic o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start2 = 1'b1; op2 = o; a2 = x; b2 = y;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic start_op1(input logic o, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        start1 = 1'b1; op1 = o; a1 = x; b1 = y;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy2, done2, result2, neg2, cout2, aux2, auy2, aus2, aucin2} !== 23'h0) begin
            failures++;
            $display("FAIL reset_n2 got=%h exp=0", {busy2, done2, result2, neg2, cout2, aux2, auy2, aus2, aucin2});
        end
        checks++;
        if ({busy1, done1, result1, neg1, cout1, aux1, auy1, aus1, aucin1} !== 19'h0) begin
            failures++;
            $display("FAIL reset_n1 got=%h exp=0", {busy1, done1, result1, neg1, cout1, aux1, auy1, aus1, aucin1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_basic;
        start_op2(1'b0, 8'h3A, 8'h25);
        checks++;
        if ({busy2, done2, aux2, auy2, aus2, aucin2} !== {2'b10, 4'hA, 4'h5, 2'b00}) begin
            failures++;
            $display("FAIL add_basic_nib0 got=%h exp=%h", {busy2, done2, aux2, auy2, aus2, aucin2}, {2'b10, 4'hA, 4'h5, 2'b00});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, aux2, auy2, aus2, aucin2} !== {2'b10, 4'h3, 4'h2, 2'b00}) begin
            failures++;
            $display("FAIL add_basic_nib1 got=%h exp=%h", {busy2, done2, aux2, auy2, aus2, aucin2}, {2'b10, 4'h3, 4'h2, 2'b00});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, result2, neg2, cout2} !== {2'b01, 8'h5F, 2'b00}) begin
            failures++;
            $display("FAIL add_basic_done got=%h exp=%h", {busy2, done2, result2, neg2, cout2}, {2'b01, 8'h5F, 2'b00});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, result2, aux2, auy2, aus2, aucin2} !== {2'b00, 8'h5F, 10'h0}) begin
            failures++;
            $display("FAIL add_basic_hold got=%h exp=%h", {busy2, done2, result2, aux2, auy2, aus2, aucin2}, {2'b00, 8'h5F, 10'h0});
        end
    endtask

    task automatic test_add_carry;
        start_op2(1'b0, 8'hF0, 8'h20);
        @(negedge clk);
        checks++;
        if ({aux2, auy2, aucin2, aucout2} !== {4'hF, 4'h2, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_carry_nib1 got=%h exp=%h", {aux2, auy2, aucin2, aucout2}, {4'hF, 4'h2, 1'b0, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({done2, result2, neg2, cout2} !== {1'b1, 8'h10, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_carry_done got=%h exp=%h", {done2, result2, neg2, cout2}, {1'b1, 8'h10, 1'b0, 1'b1});
        end
    endtask

    task automatic test_sub_pos;
        start_op2(1'b1, 8'h50, 8'h23);
        checks++;
        if ({aux2, auy2, aus2, aucin2} !== {4'h0, 4'h3, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_pos_nib0 got=%h exp=%h", {aux2, auy2, aus2, aucin2}, {4'h0, 4'h3, 1'b1, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({aux2, auy2, aus2, aucin2} !== {4'h5, 4'h2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_pos_nib1 got=%h exp=%h", {aux2, auy2, aus2, aucin2}, {4'h5, 4'h2, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({done2, result2, neg2, cout2} !== {1'b1, 8'h2D, 2'b00}) begin
            failures++;
            $display("FAIL sub_pos_done got=%h exp=%h", {done2, result2, neg2, cout2}, {1'b1, 8'h2D, 2'b00});
        end
        start_op2(1'b1, 8'h77, 8'h77);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done2, result2, neg2, cout2} !== {1'b1, 8'h00, 2'b00}) begin
            failures++;
            $display("FAIL sub_equal_done got=%h exp=%h", {done2, result2, neg2, cout2}, {1'b1, 8'h00, 2'b00});
        end
    endtask

    task automatic test_sub_neg;
        start_op2(1'b1, 8'h23, 8'h50);
        @(negedge clk);
        checks++;
        if ({aux2, auy2, aucin2, aucout2} !== {4'h2, 4'h5, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_neg_nib1 got=%h exp=%h", {aux2, auy2, aucin2, aucout2}, {4'h2, 4'h5, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, result2, neg2, aux2, auy2, aus2, aucin2} !== {2'b10, 8'hD3, 1'b1, 4'h0, 4'h3, 2'b11}) begin
            failures++;
            $display("FAIL sub_neg_neg0 got=%h exp=%h", {busy2, done2, result2, neg2, aux2, auy2, aus2, aucin2}, {2'b10, 8'hD3, 1'b1, 4'h0, 4'h3, 2'b11});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, aux2, auy2, aus2, aucin2} !== {2'b10, 4'h0, 4'hD, 2'b10}) begin
            failures++;
            $display("FAIL sub_neg_neg1 got=%h exp=%h", {busy2, done2, aux2, auy2, aus2, aucin2}, {2'b10, 4'h0, 4'hD, 2'b10});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, result2, neg2, cout2} !== {2'b01, 8'h2D, 2'b10}) begin
            failures++;
            $display("FAIL sub_neg_done got=%h exp=%h", {busy2, done2, result2, neg2, cout2}, {2'b01, 8'h2D, 2'b10});
        end
    endtask

    task automatic test_start_ignored;
        start_op2(1'b0, 8'h12, 8'h34);
        start2 = 1'b1; op2 = 1'b1; a2 = 8'hFF; b2 = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done2, result2, neg2, cout2} !== {1'b1, 8'h46, 2'b00}) begin
            failures++;
            $display("FAIL ignore_busy_done got=%h exp=%h", {done2, result2, neg2, cout2}, {1'b1, 8'h46, 2'b00});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, result2} !== {2'b00, 8'h46}) begin
            failures++;
            $display("FAIL ignore_in_done got=%h exp=%h", {busy2, done2, result2}, {2'b00, 8'h46});
        end
        start2 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int done_seen;
        start_op2(1'b1, 8'h23, 8'h50);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy2, done2, result2, neg2, cout2, aux2, auy2, aus2, aucin2} !== 23'h0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0", {busy2, done2, result2, neg2, cout2, aux2, auy2, aus2, aucin2});
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done2 || busy2) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_idle got=%0d active cycles exp=0", done_seen);
        end
    endtask

    task automatic test_back_to_back;
        start_op2(1'b0, 8'h01, 8'h02);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done2, result2} !== {1'b1, 8'h03}) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", {done2, result2}, {1'b1, 8'h03});
        end
        @(negedge clk);
        start2 = 1'b1; op2 = 1'b1; a2 = 8'h50; b2 = 8'h23;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if ({busy2, aux2, auy2, aus2, aucin2} !== {1'b1, 4'h0, 4'h3, 2'b11}) begin
            failures++;
            $display("FAIL b2b_accept got=%h exp=%h", {busy2, aux2, auy2, aus2, aucin2}, {1'b1, 4'h0, 4'h3, 2'b11});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done2, result2, neg2} !== {1'b1, 8'h2D, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", {done2, result2, neg2}, {1'b1, 8'h2D, 1'b0});
        end
    endtask

    task automatic test_nib1;
        start_op1(1'b1, 4'h3, 4'h9);
        checks++;
        if ({busy1, done1, aux1, auy1, aus1, aucin1} !== {2'b10, 4'h3, 4'h9, 2'b11}) begin
            failures++;
            $display("FAIL nib1_sub_add got=%h exp=%h", {busy1, done1, aux1, auy1, aus1, aucin1}, {2'b10, 4'h3, 4'h9, 2'b11});
        end
        @(negedge clk);
        checks++;
        if ({busy1, done1, aux1, auy1, aus1, aucin1} !== {2'b10, 4'h0, 4'hA, 2'b11}) begin
            failures++;
            $display("FAIL nib1_sub_neg got=%h exp=%h", {busy1, done1, aux1, auy1, aus1, aucin1}, {2'b10, 4'h0, 4'hA, 2'b11});
        end
        @(negedge clk);
        checks++;
        if ({done1, result1, neg1, cout1} !== {1'b1, 4'h6, 2'b10}) begin
            failures++;
            $display("FAIL nib1_sub_done got=%h exp=%h", {done1, result1, neg1, cout1}, {1'b1, 4'h6, 2'b10});
        end
        start_op1(1'b0, 4'h9, 4'h8);
        @(negedge clk);
        checks++;
        if ({done1, result1, neg1, cout1} !== {1'b1, 4'h1, 2'b01}) begin
            failures++;
            $display("FAIL nib1_add_done got=%h exp=%h", {done1, result1, neg1, cout1}, {1'b1, 4'h1, 2'b01});
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub_pos();
        test_sub_neg();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_nib1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
